// File: rtl/dataram_pkg.sv
// Shared definitions for the data RAM with bit read-modify-write engine:
// bit-op encodings, controller states and the single-bit modify helper.
package dataram_pkg;

  localparam int BIT_REGION_BYTES = 16;

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_SET = 2'b01,
    OP_CLR = 2'b10,
    OP_CPL = 2'b11
  } bit_op_e;

  // Read-side encoding that turns a bit read into test-and-clear.
  localparam logic [1:0] OP_TCLR = 2'b11;

  typedef enum logic [1:0] {
    INIT = 2'b00,
    IDLE = 2'b01,
    RMW  = 2'b10
  } state_e;

  function automatic logic [7:0] bit_modify(input logic [7:0] old_byte,
                                            input logic [2:0] idx,
                                            input bit_op_e    op,
                                            input logic       bin);
    logic [7:0] new_byte;
    new_byte = old_byte;
    case (op)
      OP_MOV:  new_byte[idx] = bin;
      OP_SET:  new_byte[idx] = 1'b1;
      OP_CLR:  new_byte[idx] = 1'b0;
      default: new_byte[idx] = ~old_byte[idx];
    endcase
    return new_byte;
  endfunction

endpackage

// File: rtl/dataram_mem.sv
// Single-port DEPTH x 8 storage: synchronous write, combinational read, so a
// write committed on one edge is seen by any read on the following edge.
module dataram_mem #(
  parameter int  DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] r_mem [DEPTH];

  // NOTE: the array has no reset; zeroing is done by the controller's INIT sweep.
  always_ff @(posedge clk) begin
    if (we) r_mem[addr] <= wdata;
  end

  assign rdata = r_mem[addr];

endmodule

// File: rtl/dataram_rmw.sv
// 8051-style internal data RAM front end: valid/ready request port, registered
// read data, atomic bit read-modify-write and an optional clear sweep after reset.
module dataram_rmw
  import dataram_pkg::*;
#(
  parameter int         DEPTH          = 256,
  parameter logic [7:0] BIT_BASE       = 8'h20,
  parameter bit         CLEAR_ON_RESET = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       CS,
  output logic       ready,
  input  logic       RW,
  input  logic       Bb,
  input  logic [1:0] op,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       bin,
  output logic [7:0] dout,
  output logic       bout,
  output logic       rvalid,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);

  state_e     r_state, w_next;
  logic [7:0] r_cnt, r_byte;
  logic [2:0] r_bit;
  bit_op_e    r_op;
  logic       r_bin;

  logic       w_accept, w_illegal, w_tclr, w_rmw_req, w_we, w_mem_we;
  logic [7:0] w_bit_byte, w_req_byte, w_maddr, w_wdata, w_rdata;

  assign w_accept   = !CS && ready;
  assign w_bit_byte = BIT_BASE + {4'b0000, addr[6:3]};
  assign w_req_byte = Bb ? addr : w_bit_byte;
  assign w_illegal  = Bb ? ({1'b0, addr} >= 9'(DEPTH)) : addr[7];
  assign w_tclr     = RW && !Bb && (op == OP_TCLR);
  assign w_rmw_req  = !Bb && (!RW || w_tclr);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    ready   = 1'b0;
    w_we    = 1'b0;
    w_maddr = w_req_byte;
    w_wdata = din;
    case (r_state)
      INIT: begin
        w_maddr = r_cnt;
        w_wdata = 8'h00;
        w_we    = CLEAR_ON_RESET;
        if (!CLEAR_ON_RESET || r_cnt == 8'(DEPTH - 1)) w_next = IDLE;
      end
      IDLE: begin
        ready = 1'b1;
        if (w_accept && !w_illegal) begin
          w_we = Bb && !RW;
          if (w_rmw_req) w_next = RMW;
        end
      end
      RMW: begin
        w_maddr = r_byte;
        w_wdata = bit_modify(w_rdata, r_bit, r_op, r_bin);
        w_we    = 1'b1;
        w_next  = IDLE;
      end
      default: w_next = INIT;
    endcase
  end

  // NOTE: reset is synchronous, so the write strobe must be gated here too or a
  // reset landing in the RMW cycle would still commit the pending write-back.
  assign w_mem_we = w_we && rst_n;

  dataram_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .addr  (w_maddr[AW-1:0]),
    .wdata (w_wdata),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= 8'h00;
      r_byte <= 8'h00;
      r_bit  <= 3'd0;
      r_op   <= OP_MOV;
      r_bin  <= 1'b0;
      dout   <= 8'h00;
      bout   <= 1'b0;
      rvalid <= 1'b0;
      err    <= 1'b0;
    end else begin
      rvalid <= 1'b0;
      err    <= 1'b0;
      if (r_state == INIT) r_cnt <= r_cnt + 8'd1;
      if (r_state == IDLE && w_accept) begin
        if (w_illegal) begin
          err <= 1'b1;
          if (RW) begin
            rvalid <= 1'b1;
            dout   <= 8'h00;
            bout   <= 1'b0;
          end
        end else begin
          if (RW) begin
            rvalid <= 1'b1;
            if (Bb) dout <= w_rdata;
            else    bout <= w_rdata[addr[2:0]];
          end
          // Test-and-clear reuses the RMW path as a plain CLR.
          if (w_rmw_req) begin
            r_byte <= w_bit_byte;
            r_bit  <= addr[2:0];
            r_op   <= w_tclr ? OP_CLR : bit_op_e'(op);
            r_bin  <= bin;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dataram_rmw.sv
// Directed bench for dataram_rmw: three instances (256/clear, 128/clear,
// 256/no-clear) share the request bus; each has its own reset.
module tb_dataram_rmw;
  import dataram_pkg::*;

  logic       clk;
  logic       rst0, rst1, rst2;
  logic       CS, RW, Bb, bin;
  logic [1:0] op;
  logic [7:0] addr, din;

  logic       ready0, bout0, rvalid0, err0;
  logic       ready1, bout1, rvalid1, err1;
  logic       ready2, bout2, rvalid2, err2;
  logic [7:0] dout0, dout1, dout2;

  int n_pass  = 0;
  int n_total = 0;
  int n;

  dataram_rmw #(.DEPTH(256), .BIT_BASE(8'h20), .CLEAR_ON_RESET(1'b1)) u_dut0 (
    .clk(clk), .rst_n(rst0), .CS(CS), .ready(ready0), .RW(RW), .Bb(Bb), .op(op),
    .addr(addr), .din(din), .bin(bin), .dout(dout0), .bout(bout0),
    .rvalid(rvalid0), .err(err0));

  dataram_rmw #(.DEPTH(128), .BIT_BASE(8'h20), .CLEAR_ON_RESET(1'b1)) u_dut1 (
    .clk(clk), .rst_n(rst1), .CS(CS), .ready(ready1), .RW(RW), .Bb(Bb), .op(op),
    .addr(addr), .din(din), .bin(bin), .dout(dout1), .bout(bout1),
    .rvalid(rvalid1), .err(err1));

  dataram_rmw #(.DEPTH(256), .BIT_BASE(8'h20), .CLEAR_ON_RESET(1'b0)) u_dut2 (
    .clk(clk), .rst_n(rst2), .CS(CS), .ready(ready2), .RW(RW), .Bb(Bb), .op(op),
    .addr(addr), .din(din), .bin(bin), .dout(dout2), .bout(bout2),
    .rvalid(rvalid2), .err(err2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rw_v, input logic bb_v, input logic [1:0] op_v,
                       input logic [7:0] a, input logic [7:0] d, input logic b);
    CS   = 1'b0;
    RW   = rw_v;
    Bb   = bb_v;
    op   = op_v;
    addr = a;
    din  = d;
    bin  = b;
  endtask

  function automatic logic rdy(input int which);
    case (which)
      0:       return ready0;
      1:       return ready1;
      default: return ready2;
    endcase
  endfunction

  task automatic wait_ready(input int which, input int limit, output int cycles);
    cycles = 0;
    while (!rdy(which) && cycles < limit) begin
      step();
      cycles++;
    end
  endtask

  initial begin
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    drive(1'b1, 1'b1, 2'b00, 8'h07, 8'h00, 1'b0);
    step();
    step();
    check("rst_ready",  ready0,  1'b0);
    check("rst_rvalid", rvalid0, 1'b0);
    check("rst_err",    err0,    1'b0);
    check("rst_dout",   dout0,   8'h00);
    check("rst_bout",   bout0,   1'b0);

    // Clear sweep: ready low for DEPTH cycles while a read is held pending.
    rst0 = 1'b1;
    wait_ready(0, 1000, n);
    check("init_cycles", n, 256);
    check("init_no_rvalid", rvalid0, 1'b0);
    step();
    check("rd07_rvalid", rvalid0, 1'b1);
    check("rd07_dout",   dout0,   8'h00);

    // Byte writes then back-to-back reads.
    drive(1'b0, 1'b1, 2'b00, 8'h07, 8'h78, 1'b0); step();
    check("wr_ready", ready0, 1'b1);
    drive(1'b0, 1'b1, 2'b00, 8'h22, 8'h87, 1'b0); step();
    drive(1'b0, 1'b1, 2'b00, 8'h30, 8'h55, 1'b0); step();
    check("wr_no_rvalid", rvalid0, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 8'h07, 8'h00, 1'b0); step();
    check("rd07", dout0, 8'h78);
    drive(1'b1, 1'b1, 2'b00, 8'h22, 8'h00, 1'b0); step();
    check("rd22", dout0, 8'h87);
    check("rd22_rvalid", rvalid0, 1'b1);
    drive(1'b1, 1'b1, 2'b00, 8'h30, 8'h00, 1'b0); step();
    check("rd30", dout0, 8'h55);
    check("rd30_rvalid", rvalid0, 1'b1);

    // MOV bin=1 to bit 0x08 -> byte 0x21 bit 0.
    drive(1'b0, 1'b0, OP_MOV, 8'h08, 8'h00, 1'b1); step();
    CS = 1'b1;
    check("mov_busy", ready0, 1'b0);
    step();
    check("mov_done", ready0, 1'b1);
    drive(1'b1, 1'b1, 2'b00, 8'h21, 8'h00, 1'b0); step();
    check("rd21_mov", dout0, 8'h01);

    // CPL bit 0x07 -> byte 0x20 bit 7.
    drive(1'b0, 1'b0, OP_CPL, 8'h07, 8'h00, 1'b0); step();
    CS = 1'b1;
    check("cpl_busy", ready0, 1'b0);
    step();
    check("cpl_done", ready0, 1'b1);
    drive(1'b1, 1'b1, 2'b00, 8'h20, 8'h00, 1'b0); step();
    check("rd20_cpl", dout0, 8'h80);

    // Plain bit reads of byte 0x22 = 0x87; op 01/10 behave as plain.
    drive(1'b1, 1'b0, 2'b00, 8'h10, 8'h00, 1'b0); step();
    check("bitrd10", bout0, 1'b1);
    check("bitrd10_rvalid", rvalid0, 1'b1);
    check("bitrd10_ready", ready0, 1'b1);
    drive(1'b1, 1'b0, 2'b01, 8'h16, 8'h00, 1'b0); step();
    check("bitrd16", bout0, 1'b0);
    check("bitrd16_ready", ready0, 1'b1);
    drive(1'b1, 1'b0, 2'b10, 8'h17, 8'h00, 1'b0); step();
    check("bitrd17", bout0, 1'b1);

    // Test-and-clear bit 0x11 (0x22 bit 1).
    drive(1'b1, 1'b0, OP_TCLR, 8'h11, 8'h00, 1'b0); step();
    CS = 1'b1;
    check("tclr1_rvalid", rvalid0, 1'b1);
    check("tclr1_bout",   bout0,   1'b1);
    check("tclr1_busy",   ready0,  1'b0);
    step();
    drive(1'b1, 1'b1, 2'b00, 8'h22, 8'h00, 1'b0); step();
    check("rd22_tclr1", dout0, 8'h85);
    drive(1'b1, 1'b0, OP_TCLR, 8'h11, 8'h00, 1'b0); step();
    CS = 1'b1;
    check("tclr2_bout",   bout0,   1'b0);
    check("tclr2_rvalid", rvalid0, 1'b1);
    step();
    drive(1'b1, 1'b1, 2'b00, 8'h22, 8'h00, 1'b0); step();
    check("rd22_tclr2", dout0, 8'h85);

    // Illegal bit write into SFR space: err pulse, no RMW, nothing written.
    drive(1'b0, 1'b0, OP_SET, 8'h80, 8'h00, 1'b0); step();
    CS = 1'b1;
    check("sfr_err",       err0,    1'b1);
    check("sfr_no_rvalid", rvalid0, 1'b0);
    check("sfr_ready",     ready0,  1'b1);
    step();
    check("sfr_err_pulse", err0, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 8'h20, 8'h00, 1'b0); step();
    check("rd20_after_sfr", dout0, 8'h80);

    // Illegal test-and-clear read returns bout=0 with rvalid.
    drive(1'b1, 1'b0, 2'b00, 8'h17, 8'h00, 1'b0); step();
    check("bitrd17_again", bout0, 1'b1);
    drive(1'b1, 1'b0, OP_TCLR, 8'h85, 8'h00, 1'b0); step();
    check("sfr_rd_err",    err0,    1'b1);
    check("sfr_rd_rvalid", rvalid0, 1'b1);
    check("sfr_rd_bout",   bout0,   1'b0);
    check("sfr_rd_ready",  ready0,  1'b1);

    // Second reset re-runs the sweep and zeroes previously written bytes.
    drive(1'b1, 1'b1, 2'b00, 8'h07, 8'h00, 1'b0);
    rst0 = 1'b0;
    step();
    rst0 = 1'b1;
    wait_ready(0, 1000, n);
    check("reinit_cycles", n, 256);
    step();
    check("reclear_07", dout0, 8'h00);
    rst0 = 1'b0;

    // DEPTH=128: byte addresses >= 0x80 are illegal.
    rst1 = 1'b1;
    wait_ready(1, 1000, n);
    check("init128_cycles", n, 128);
    drive(1'b0, 1'b1, 2'b00, 8'h10, 8'h3C, 1'b0); step();
    drive(1'b0, 1'b1, 2'b00, 8'h90, 8'hAA, 1'b0); step();
    check("wr90_err",       err1,    1'b1);
    check("wr90_no_rvalid", rvalid1, 1'b0);
    drive(1'b1, 1'b1, 2'b00, 8'h10, 8'h00, 1'b0); step();
    check("rd10_noerr", err1,  1'b0);
    check("rd10_128",   dout1, 8'h3C);
    drive(1'b1, 1'b1, 2'b00, 8'h90, 8'h00, 1'b0); step();
    check("rd90_err",    err1,    1'b1);
    check("rd90_rvalid", rvalid1, 1'b1);
    check("rd90_dout",   dout1,   8'h00);
    rst1 = 1'b0;

    // No clear sweep; reset during RMW aborts the write-back.
    CS = 1'b1;
    rst2 = 1'b1;
    wait_ready(2, 1000, n);
    check("noclr_init_cycles", n, 1);
    drive(1'b0, 1'b1, 2'b00, 8'h22, 8'h00, 1'b0); step();
    drive(1'b0, 1'b0, OP_SET, 8'h10, 8'h00, 1'b0); step();
    CS = 1'b1;
    check("set_busy", ready2, 1'b0);
    rst2 = 1'b0;
    step();
    check("rst_rmw_ready", ready2, 1'b0);
    rst2 = 1'b1;
    wait_ready(2, 1000, n);
    check("rst_rmw_init_cycles", n, 1);
    drive(1'b1, 1'b1, 2'b00, 8'h22, 8'h00, 1'b0); step();
    check("rd22_after_abort", dout2,   8'h00);
    check("rd22_abort_valid", rvalid2, 1'b1);
    CS = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
